// File: rtl/mem_xbar_arb.sv
// mem_xbar_arb: two-master round-robin arbiter onto NSLV address-decoded slave ports
// Ports: xbar_clk_i/xbar_rst_i clock and sync active-high reset;
//   m0_* fetch master (read-only), m1_* load/store master, each with a one-cycle rsp_valid;
//   s_req_valid_o/s_req_ready_i per-slave request handshake, s_wen/addr/wdata/wmask shared payload;
//   s_rsp_valid_i/s_rdata_i per-slave response.
// Optional: define MEM_XBAR_TIMEOUT_EN to abort a slave access after TIMEOUT_CYC cycles with err=1.
module mem_xbar_arb #(
  parameter int NSLV = 2,
  parameter int DATA_W = 64,
  parameter logic [NSLV*DATA_W-1:0] SLV_BASE = {64'h0000_0000_0200_0000, 64'h0000_0000_8000_0000},
  parameter logic [NSLV*DATA_W-1:0] SLV_MASK = {64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_F800_0000},
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   xbar_clk_i,
  input  logic                   xbar_rst_i,
  input  logic                   m0_req_i,
  input  logic [DATA_W-1:0]      m0_addr_i,
  output logic                   m0_rsp_valid_o,
  output logic                   m0_rsp_err_o,
  output logic [DATA_W-1:0]      m0_rdata_o,
  input  logic                   m1_req_i,
  input  logic                   m1_wen_i,
  input  logic [DATA_W-1:0]      m1_addr_i,
  input  logic [DATA_W-1:0]      m1_wdata_i,
  input  logic [7:0]             m1_wmask_i,
  output logic                   m1_rsp_valid_o,
  output logic                   m1_rsp_err_o,
  output logic [DATA_W-1:0]      m1_rdata_o,
  output logic [NSLV-1:0]        s_req_valid_o,
  input  logic [NSLV-1:0]        s_req_ready_i,
  output logic                   s_wen_o,
  output logic [DATA_W-1:0]      s_addr_o,
  output logic [DATA_W-1:0]      s_wdata_o,
  output logic [7:0]             s_wmask_o,
  input  logic [NSLV-1:0]        s_rsp_valid_i,
  input  logic [NSLV*DATA_W-1:0] s_rdata_i
);
  localparam int SW = NSLV > 1 ? $clog2(NSLV) : 1;
  typedef enum logic [1:0] {IDLE, SREQ, SRSP, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, gnt_q, gnt_d, wen_q, wen_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0] wmask_q, wmask_d;
  logic [SW-1:0] sel_q, sel_d, hit_sel;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d, rsp_data, nxt_addr;
  logic m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic gnt_nxt, hit, rsp_wr, rsp_err, timeout;
  // Ties go to the master not granted last; a lone request always wins.
  always_comb begin
    gnt_nxt = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
    nxt_addr = gnt_nxt ? m1_addr_i : m0_addr_i;
    hit = 1'b0;
    hit_sel = '0;
    // Scanning downward lets the lowest matching window win.
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((nxt_addr & SLV_MASK[i*DATA_W +: DATA_W]) == SLV_BASE[i*DATA_W +: DATA_W]) begin
        hit = 1'b1;
        hit_sel = SW'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gnt_d = gnt_q;
    wen_d = wen_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    sel_d = sel_q;
    rsp_wr = 1'b0;
    rsp_err = 1'b1;
    rsp_data = '0;
    case (state_q)
      IDLE: if (m0_req_i || m1_req_i) begin
        gnt_d = gnt_nxt;
        last_d = gnt_nxt;
        wen_d = gnt_nxt & m1_wen_i;
        addr_d = nxt_addr;
        wdata_d = gnt_nxt ? m1_wdata_i : '0;
        wmask_d = gnt_nxt ? m1_wmask_i : 8'h00;
        sel_d = hit_sel;
        state_d = hit ? SREQ : RESP;
        rsp_wr = ~hit;
      end
      SREQ: if (timeout) begin
        state_d = RESP;
        rsp_wr = 1'b1;
      end else if (s_req_ready_i[sel_q]) begin
        state_d = SRSP;
      end
      SRSP: if (timeout) begin
        state_d = RESP;
        rsp_wr = 1'b1;
      end else if (s_rsp_valid_i[sel_q]) begin
        state_d = RESP;
        rsp_wr = 1'b1;
        rsp_err = 1'b0;
        rsp_data = wen_q ? '0 : s_rdata_i[sel_q*DATA_W +: DATA_W];
      end
      default: state_d = IDLE;
    endcase
    // Response registers update only when their master's response is formed, so they hold until the next one.
    m0_rdata_d = (rsp_wr && !gnt_d) ? rsp_data : m0_rdata_q;
    m0_err_d = (rsp_wr && !gnt_d) ? rsp_err : m0_err_q;
    m1_rdata_d = (rsp_wr && gnt_d) ? rsp_data : m1_rdata_q;
    m1_err_d = (rsp_wr && gnt_d) ? rsp_err : m1_err_q;
  end
`ifdef MEM_XBAR_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == SREQ || state_q == SRSP) ? cnt_q + 16'd1 : '0;
  assign timeout = (state_q == SREQ || state_q == SRSP) && cnt_q == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge xbar_clk_i) cnt_q <= xbar_rst_i ? '0 : cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge xbar_clk_i) begin
    if (xbar_rst_i) begin
      state_q <= IDLE;
      last_q <= 1'b0;
      gnt_q <= 1'b0;
      wen_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      sel_q <= '0;
      m0_rdata_q <= '0;
      m0_err_q <= 1'b0;
      m1_rdata_q <= '0;
      m1_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      sel_q <= sel_d;
      m0_rdata_q <= m0_rdata_d;
      m0_err_q <= m0_err_d;
      m1_rdata_q <= m1_rdata_d;
      m1_err_q <= m1_err_d;
    end
  end
  assign s_req_valid_o = (state_q == SREQ) ? NSLV'(1) << sel_q : '0;
  assign s_wen_o = wen_q;
  assign s_addr_o = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_wmask_o = wmask_q;
  assign m0_rsp_valid_o = state_q == RESP && !gnt_q;
  assign m1_rsp_valid_o = state_q == RESP && gnt_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m0_rsp_err_o = m0_err_q;
  assign m1_rdata_o = m1_rdata_q;
  assign m1_rsp_err_o = m1_err_q;
endmodule

// File: tb/tb_mem_xbar_arb.sv
// tb_mem_xbar_arb: directed vector bench for mem_xbar_arb with a simple slave responder
module tb_mem_xbar_arb;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic m0_req = 1'b0, m1_req = 1'b0, m1_wen = 1'b0;
  logic [63:0] m0_addr = '0, m1_addr = '0, m1_wdata = '0;
  logic [7:0] m1_wmask = '0;
  logic m0_rv, m0_err, m1_rv, m1_err, s_wen;
  logic [63:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [7:0] s_wmask;
  logic [1:0] s_req_valid, s_ready = '0, s_rsp_valid, mdl_rsp = '0, force_rsp = '0, hs_mask = '0;
  logic [127:0] s_rdata = '0;
  assign s_rsp_valid = mdl_rsp | force_rsp;
  int checks = 0, failures = 0;
  int rdy_dly = 0, vcnt = 0;
  bit rsp_en = 1'b1;
  logic [63:0] mdl_rdata [2];
  logic mdl_err [2];
  mem_xbar_arb #(
    .NSLV(2), .DATA_W(64),
    .SLV_BASE({64'h0000_0000_8000_0000, 64'h0000_0000_0200_0000}),
    .SLV_MASK({64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_FFFF_0000}),
    .TIMEOUT_CYC(8)
  ) dut (
    .xbar_clk_i(clk), .xbar_rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr),
    .m0_rsp_valid_o(m0_rv), .m0_rsp_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_wen_i(m1_wen), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wmask_i(m1_wmask),
    .m1_rsp_valid_o(m1_rv), .m1_rsp_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .s_req_valid_o(s_req_valid), .s_req_ready_i(s_ready),
    .s_wen_o(s_wen), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wmask_o(s_wmask),
    .s_rsp_valid_i(s_rsp_valid), .s_rdata_i(s_rdata)
  );
  // Slave responder: ready after rdy_dly cycles of valid, response the cycle after the handshake.
  always @(negedge clk) begin
    mdl_rsp = rsp_en ? hs_mask : 2'b00;
    hs_mask = '0;
    s_ready = '0;
    if (rst || s_req_valid == 2'b00) vcnt = 0;
    else begin
      vcnt++;
      if (vcnt > rdy_dly) begin
        s_ready = s_req_valid;
        hs_mask = s_req_valid;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    bit m; bit wen; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask;
    int rdy; int sl; logic [63:0] sdata; bit err; logic [63:0] rdata; int lat;
  } vec_t;
  vec_t v [10];
  task automatic run_vec(input vec_t x);
    int lat = 0, saw = -1;
    bit got = 0, bad = 0;
    @(negedge clk);
    rdy_dly = x.rdy;
    rsp_en = 1'b1;
    s_rdata = (x.sl == 0) ? {~x.sdata, x.sdata} : {x.sdata, ~x.sdata};
    if (x.m) begin
      m1_req = 1'b1; m1_wen = x.wen; m1_addr = x.addr; m1_wdata = x.wdata; m1_wmask = x.wmask;
    end else begin
      m0_req = 1'b1; m0_addr = x.addr;
    end
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (s_req_valid != 2'b00) begin
        saw = s_req_valid[1] ? 1 : 0;
        if (s_req_valid != (2'b01 << x.sl) || s_addr != x.addr || s_wen != x.wen ||
            s_wdata != (x.m ? x.wdata : 64'h0) || s_wmask != (x.m ? x.wmask : 8'h00)) bad = 1;
      end
      if (x.m ? m0_rv : m1_rv) bad = 1;
      if (x.m ? m1_rv : m0_rv) begin
        got = 1;
        lat = c;
        chk("rsp_err", x.m ? m1_err : m0_err, x.err);
        chk("rsp_rdata", x.m ? m1_rdata : m0_rdata, x.rdata);
        m0_req = 1'b0; m1_req = 1'b0; m1_wen = 1'b0;
      end
    end
    chk("latency", lat, x.lat);
    chk("slave_sel", saw, x.sl);
    chk("payload_stable", bad, 0);
    mdl_rdata[x.m] = x.rdata;
    mdl_err[x.m] = x.err;
    chk("other_rdata_hold", x.m ? m0_rdata : m1_rdata, mdl_rdata[!x.m]);
    chk("other_err_hold", x.m ? m0_err : m1_err, mdl_err[!x.m]);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m1_wen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_rdata = '{64'h0, 64'h0};
    mdl_err = '{1'b0, 1'b0};
  endtask
  initial begin
    int ord [4];
    int n, lat, vhigh;
    bit got, bad;
    v[0] = '{0, 0, 64'h8000_0000, 64'h0, 8'h00, 0, 1, 64'h1122_3344_5566_7788, 0, 64'h1122_3344_5566_7788, 3};
    v[1] = '{1, 1, 64'h0200_4000, 64'hDEAD_BEEF, 8'h0F, 4, 0, 64'h5555_6666_7777_8888, 0, 64'h0, 7};
    v[2] = '{1, 0, 64'h1000_0000, 64'h0, 8'h00, 0, -1, 64'h9999_AAAA_BBBB_CCCC, 1, 64'h0, 1};
    v[3] = '{0, 0, 64'hFFFF_0000_0000_0000, 64'h0, 8'h00, 0, -1, 64'h1234, 1, 64'h0, 1};
    v[4] = '{0, 0, 64'h8800_0000, 64'h0, 8'h00, 0, -1, 64'h5678, 1, 64'h0, 1};
    v[5] = '{1, 0, 64'h0201_0000, 64'h0, 8'h00, 0, -1, 64'h9ABC, 1, 64'h0, 1};
    v[6] = '{1, 1, 64'h8000_0100, 64'h0123, 8'hFF, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, 3};
    v[7] = '{1, 0, 64'h8000_0010, 64'h0, 8'h00, 1, 1, 64'hA5A5_0F0F_1234_5678, 0, 64'hA5A5_0F0F_1234_5678, 4};
    v[8] = '{0, 0, 64'h87FF_FFF8, 64'h0, 8'h00, 2, 1, 64'hCAFE_F00D_0000_0001, 0, 64'hCAFE_F00D_0000_0001, 5};
    v[9] = '{0, 0, 64'h0200_FFF8, 64'h0, 8'h00, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 3};
    mdl_rdata = '{64'h0, 64'h0};
    mdl_err = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_s_req_valid", s_req_valid, 0);
    chk("rst_rsp_valid", {m0_rv, m1_rv}, 0);
    chk("rst_rsp_err", {m0_err, m1_err}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_s_wen_wmask", {s_wen, s_wmask}, 0);
    for (int i = 0; i < 10; i++) run_vec(v[i]);
    // Reset while waiting in SRSP; the slave answers after reset and must be ignored.
    @(negedge clk);
    rsp_en = 1'b0; rdy_dly = 0;
    s_rdata = {64'hBAD0_BAD0_BAD0_BAD0, 64'h0};
    m0_req = 1'b1; m0_addr = 64'h8000_0000;
    @(negedge clk);
    chk("rst_mid_sreq", s_req_valid, 2'b10);
    @(negedge clk);
    chk("rst_mid_srsp", s_req_valid, 2'b00);
    rst = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; force_rsp = 2'b10;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      force_rsp = 2'b00;
      if (m0_rv || m1_rv || s_req_valid != 2'b00) bad = 1;
    end
    chk("rst_mid_quiet", bad, 0);
    chk("rst_mid_m0_rdata", m0_rdata, 0);
    chk("rst_mid_m1_rdata", m1_rdata, 0);
    chk("rst_mid_err", {m0_err, m1_err}, 0);
    chk("rst_mid_s_addr", s_addr, 0);
    // Round robin: two rounds of simultaneous requests after reset.
    do_reset();
    rsp_en = 1'b1; rdy_dly = 0;
    s_rdata = {64'h1111, 64'h0};
    ord = '{-1, -1, -1, -1};
    n = 0;
    @(negedge clk);
    m0_addr = 64'h8000_0000; m1_addr = 64'h8000_0008; m1_wen = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0, r = 1; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (m1_rv && n < 4) begin ord[n] = 1; n++; m1_req = 1'b0; end
      if (m0_rv && n < 4) begin ord[n] = 0; n++; m0_req = 1'b0; end
      if (!m0_req && !m1_req && r < 2) begin r++; m0_req = 1'b1; m1_req = 1'b1; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rr_count", n, 4);
    chk("rr_grant0", ord[0], 1);
    chk("rr_grant1", ord[1], 0);
    chk("rr_grant2", ord[2], 1);
    chk("rr_grant3", ord[3], 0);
    // Slave that never becomes ready.
    do_reset();
    rdy_dly = 1000; rsp_en = 1'b1;
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 64'h8000_0000;
    got = 0; lat = 0; vhigh = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (s_req_valid == 2'b10) vhigh++;
      if (m0_rv) begin
        got = 1; lat = c; m0_req = 1'b0;
        chk("to_err", m0_err, 1);
        chk("to_rdata", m0_rdata, 0);
      end
    end
`ifdef MEM_XBAR_TIMEOUT_EN
    chk("to_latency", lat, 9);
    chk("to_valid_cycles", vhigh, 8);
`else
    chk("to_no_response", got, 0);
    chk("to_valid_cycles", vhigh, 40);
`endif
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
